// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: key-driven DDS parameter controller with a frequency sweep FSM
// Ports:
//   sys_clk, sys_rst_n    clock and asynchronous active-low reset
//   key_pulse[3:0]        single-cycle key strobes: [0] wave, [1] amplitude, [2] sweep start/stop, [3] phase
//   wave_select[3:0]      one-hot waveform select
//   amp_ctl[8:0]          amplitude scale (256, 128, 64)
//   freq_ctl[31:0]        frequency word
//   min_ctl[31:0]         constant zero
//   phase_ctl[11:0]       phase offset
//   sweep_active          high while the sweep runs
//   param_valid           one-cycle strobe in the first cycle any output parameter holds a new value
// Define DDS_SWEEP_TRIANGLE_EN for a triangular sweep; the default sweep is a sawtooth.
module dds_sweep_ctrl #(
    parameter logic [31:0] F_START      = 32'd8589935,
    parameter logic [31:0] F_STOP       = 32'd85899346,
    parameter logic [31:0] F_STEP       = 32'd858993,
    parameter int          DWELL_CYCLES = 50000,
    parameter logic [11:0] PHASE_STEP   = 12'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  key_pulse,
    output logic [3:0]  wave_select,
    output logic [8:0]  amp_ctl,
    output logic [31:0] freq_ctl,
    output logic [31:0] min_ctl,
    output logic [11:0] phase_ctl,
    output logic        sweep_active,
    output logic        param_valid
);
    typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;

    localparam logic [19:0] CNT_LOAD = 20'(DWELL_CYCLES - 1);

    state_t      state, state_d;
    logic [19:0] cnt, cnt_d;
    logic [3:0]  wave_d;
    logic [8:0]  amp_d;
    logic [31:0] freq_d, freq_step;
    logic [11:0] phase_d;
    logic        valid_d;
    logic [32:0] sum;

    assign sum          = {1'b0, freq_ctl} + {1'b0, F_STEP};
    assign min_ctl      = 32'd0;
    assign sweep_active = state != IDLE;

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic               dir_up, dir_up_d, dir_step;
    logic signed [32:0] diff;
    logic [32:0]        raw;

    // Direction turns at either limit; the result is clamped so odd parameter
    // sets never push the word outside [F_START, F_STOP].
    always_comb begin
        diff     = $signed({1'b0, freq_ctl}) - $signed({1'b0, F_STEP});
        dir_step = dir_up;
        raw      = sum;
        if (dir_up && sum > {1'b0, F_STOP}) begin
            dir_step = 1'b0;
            raw      = $unsigned(diff);
        end else if (!dir_up && diff < $signed({1'b0, F_START})) begin
            dir_step = 1'b1;
            raw      = sum;
        end else if (!dir_up) begin
            raw      = $unsigned(diff);
        end
        freq_step = raw < {1'b0, F_START} ? F_START : raw > {1'b0, F_STOP} ? F_STOP : raw[31:0];
    end
`else
    assign freq_step = sum > {1'b0, F_STOP} ? F_START : sum[31:0];
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        freq_d  = freq_ctl;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_up_d = dir_up;
`endif
        case (state)
            IDLE: begin
                if (key_pulse[2]) begin
                    state_d = DWELL;
                    cnt_d   = CNT_LOAD;
                end
            end
            DWELL: begin
                if (cnt == 20'd0) state_d = STEP;
                else cnt_d = cnt - 20'd1;
            end
            STEP: begin
                state_d = DWELL;
                cnt_d   = CNT_LOAD;
                freq_d  = freq_step;
`ifdef DDS_SWEEP_TRIANGLE_EN
                dir_up_d = dir_step;
`endif
            end
            default: state_d = IDLE;
        endcase
        // A stop key overrides any step update made in the same cycle.
        if (key_pulse[2] && state != IDLE) begin
            state_d = IDLE;
            cnt_d   = 20'd0;
            freq_d  = F_START;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_up_d = 1'b1;
`endif
        end
        wave_d  = key_pulse[0] ? {wave_select[2:0], wave_select[3]} : wave_select;
        amp_d   = !key_pulse[1] ? amp_ctl : amp_ctl == 9'd256 ? 9'd128 : amp_ctl == 9'd128 ? 9'd64 : 9'd256;
        phase_d = key_pulse[3] ? phase_ctl + PHASE_STEP : phase_ctl;
        valid_d = wave_d != wave_select || amp_d != amp_ctl || freq_d != freq_ctl || phase_d != phase_ctl;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= 20'd0;
            wave_select <= 4'b0001;
            amp_ctl     <= 9'd256;
            freq_ctl    <= F_START;
            phase_ctl   <= 12'd0;
            param_valid <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            wave_select <= wave_d;
            amp_ctl     <= amp_d;
            freq_ctl    <= freq_d;
            phase_ctl   <= phase_d;
            param_valid <= valid_d;
        end
    end

`ifdef DDS_SWEEP_TRIANGLE_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) dir_up <= 1'b1;
        else dir_up <= dir_up_d;
    end
`endif
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: randomized and directed checks of dds_sweep_ctrl against a behavioural model
module tb_dds_sweep_ctrl;
    localparam int FS = 100, FE = 130, FP = 10, DW = 4, PS = 1024;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  key_pulse;
    logic [3:0]  wave_select;
    logic [8:0]  amp_ctl;
    logic [31:0] freq_ctl, min_ctl;
    logic [11:0] phase_ctl;
    logic        sweep_active, param_valid;

    int n_cmp = 0, n_bad = 0;

    dds_sweep_ctrl #(
        .F_START(32'(FS)), .F_STOP(32'(FE)), .F_STEP(32'(FP)),
        .DWELL_CYCLES(DW), .PHASE_STEP(12'(PS))
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_pulse(key_pulse),
        .wave_select(wave_select), .amp_ctl(amp_ctl), .freq_ctl(freq_ctl),
        .min_ctl(min_ctl), .phase_ctl(phase_ctl), .sweep_active(sweep_active),
        .param_valid(param_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: indices into the rotation tables, a running flag and
    // the age of the current sweep frequency.
    int m_wave, m_amp, m_phase, m_freq, m_age;
    bit m_sweep, m_pv;
`ifdef DDS_SWEEP_TRIANGLE_EN
    bit m_up;
`endif
    int amp_tab[3] = '{256, 128, 64};

    function automatic int next_freq(int f);
`ifdef DDS_SWEEP_TRIANGLE_EN
        int n;
        if (m_up) begin
            if (f + FP > FE) begin m_up = 0; n = f - FP; end
            else n = f + FP;
        end else begin
            if (f - FP < FS) begin m_up = 1; n = f + FP; end
            else n = f - FP;
        end
        return n < FS ? FS : n > FE ? FE : n;
`else
        return f + FP > FE ? FS : f + FP;
`endif
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        int old_w, old_a, old_p, old_f;
        if (!sys_rst_n) begin
            m_wave = 0; m_amp = 0; m_phase = 0; m_freq = FS;
            m_age = 0; m_sweep = 0; m_pv = 0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            m_up = 1;
`endif
        end else begin
            old_w = m_wave; old_a = m_amp; old_p = m_phase; old_f = m_freq;
            if (key_pulse[0]) m_wave = (m_wave + 1) % 4;
            if (key_pulse[1]) m_amp = (m_amp + 1) % 3;
            if (key_pulse[3]) m_phase = (m_phase + PS) % 4096;
            if (key_pulse[2]) begin
                if (m_sweep) begin
                    m_sweep = 0; m_freq = FS;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    m_up = 1;
`endif
                end else begin
                    m_sweep = 1; m_age = 0;
                end
            end else if (m_sweep) begin
                if (m_age == DW) begin m_freq = next_freq(m_freq); m_age = 0; end
                else m_age++;
            end
            m_pv = old_w != m_wave || old_a != m_amp || old_p != m_phase || old_f != m_freq;
        end
    end

    always @(negedge sys_clk) begin
        logic [70:0] exp_v, act_v;
        exp_v = {4'(1 << m_wave), 9'(amp_tab[m_amp]), 32'(m_freq), 12'(m_phase), m_sweep, m_pv, 32'd0} >> 32;
        act_v = {wave_select, amp_ctl, freq_ctl, phase_ctl, sweep_active, param_valid, min_ctl} >> 32;
        n_cmp++;
        if (act_v !== exp_v || min_ctl !== 32'd0) begin
            n_bad++;
            $display("FAIL model t=%0t: wave/amp/freq/phase/act/pv got %b/%0d/%0d/%0d/%b/%b min=%0d expected %b/%0d/%0d/%0d/%b/%b min=0",
                     $time, wave_select, amp_ctl, freq_ctl, phase_ctl, sweep_active, param_valid, min_ctl,
                     4'(1 << m_wave), amp_tab[m_amp], m_freq, m_phase, m_sweep, m_pv);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic tick(input logic [3:0] k);
        cyc();
        key_pulse = k;
        cyc();
        key_pulse = 4'd0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        key_pulse = 4'd0;
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_wave"}, wave_select, 1);
        chk({name, "_amp"}, amp_ctl, 256);
        chk({name, "_freq"}, freq_ctl, FS);
        chk({name, "_phase"}, phase_ctl, 0);
        chk({name, "_active"}, sweep_active, 0);
        chk({name, "_pv"}, param_valid, 0);
    endtask

    int wave_seq[5] = '{2, 4, 8, 1, 2};
`ifdef DDS_SWEEP_TRIANGLE_EN
    int freq_seq[8] = '{100, 110, 120, 130, 120, 110, 100, 110};
`else
    int freq_seq[8] = '{100, 110, 120, 130, 100, 110, 120, 130};
`endif

    initial begin
        logic [3:0] k;
        sys_rst_n = 1'b0;
        key_pulse = 4'd0;
        repeat (3) @(posedge sys_clk);
        #2 chk_reset("reset");
        sys_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick(4'b0001);
            chk("wave_rot", wave_select, wave_seq[i]);
            chk("wave_pv", param_valid, 1);
        end
        cyc();
        chk("wave_pv_drop", param_valid, 0);

        do_reset();
        tick(4'b1011);
        chk("multi_amp", amp_ctl, 128);
        chk("multi_phase", phase_ctl, 1024);
        chk("multi_wave", wave_select, 2);
        chk("multi_pv", param_valid, 1);
        cyc();
        chk("multi_pv_single", param_valid, 0);

        do_reset();
        tick(4'b0100);
        for (int j = 1; j <= 40; j++) begin
            chk("sweep_freq", freq_ctl, freq_seq[(j - 1) / 5]);
            chk("sweep_active", sweep_active, 1);
            chk("sweep_pv", param_valid, (j > 1 && (j - 1) % 5 == 0) ? 1 : 0);
            cyc();
        end

        do_reset();
        tick(4'b0100);
        repeat (14) cyc();
        chk("stop_pre_freq", freq_ctl, 120);
        key_pulse = 4'b0100;
        cyc();
        key_pulse = 4'd0;
        chk("stop_freq", freq_ctl, FS);
        chk("stop_active", sweep_active, 0);
        chk("stop_pv", param_valid, 1);
        for (int j = 0; j < 10; j++) begin
            cyc();
            chk("stop_hold_freq", freq_ctl, FS);
        end

        do_reset();
        repeat (3) tick(4'b1000);
        chk("rst_phase_pre", phase_ctl, 3072);
        tick(4'b0100);
        cyc();
        sys_rst_n = 1'b0;
        #1 chk_reset("async_rst");
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk_reset("post_rst");
        end
        for (int j = 1; j <= 4; j++) begin
            tick(4'b1000);
            chk("phase_wrap", phase_ctl, (j * 1024) % 4096);
        end

        for (int i = 0; i < 1500; i++) begin
            k[0] = $urandom_range(0, 7) == 0;
            k[1] = $urandom_range(0, 7) == 0;
            k[2] = $urandom_range(0, 39) == 0;
            k[3] = $urandom_range(0, 7) == 0;
            if (i == 700) begin
                sys_rst_n = 1'b0;
                key_pulse = 4'd0;
                cyc();
                cyc();
                sys_rst_n = 1'b1;
            end
            key_pulse = k;
            cyc();
        end
        key_pulse = 4'd0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter F_START, default 32'd8589935, sweep start and idle frequency word (100 kHz at 50 MHz).
REQ-002 The block SHALL have parameter F_STOP, default 32'd85899346, sweep upper limit frequency word (1 MHz).
REQ-003 The block SHALL have parameter F_STEP, default 32'd858993, frequency increment per dwell (10 kHz).
REQ-004 The block SHALL have parameter DWELL_CYCLES, default 50000, clocks held at each sweep frequency, legal range 1 to 2^20.
REQ-005 The block SHALL have parameter PHASE_STEP, default 12'd1024, phase increment per phase key.
REQ-006 sys_clk  input  1  system clock, 50 MHz.
REQ-007 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_pulse  input  4  debounced single-cycle key strobes: [0] wave, [1] amplitude, [2] sweep start/stop, [3] phase.
REQ-009 wave_select  output  4  one-hot waveform select to dds.
REQ-010 amp_ctl  output  9  amplitude scale to dds.
REQ-011 freq_ctl  output  32  frequency word to dds.
REQ-012 min_ctl  output  32  constant 32'd0.
REQ-013 phase_ctl  output  12  phase offset to dds.
REQ-014 sweep_active  output  1  high while the sweep is running.
REQ-015 param_valid  output  1  one-cycle strobe, high in the first cycle any of wave_select, amp_ctl, freq_ctl or phase_ctl holds a new value.

Function
REQ-016 All key_pulse bits SHALL be sampled on the same sys_clk edge and acted on independently, so simultaneous pulses all take effect in one cycle and produce a single param_valid.
REQ-017 Outputs SHALL update on the edge that samples the pulse, giving 1-cycle latency, with param_valid high in the same cycle as the new values.
REQ-018 key_pulse[0] SHALL rotate wave_select 0001->0010->0100->1000->0001.
REQ-019 key_pulse[1] SHALL cycle amp_ctl 256->128->64->256.
REQ-020 key_pulse[3] SHALL set phase_ctl to (phase_ctl+PHASE_STEP) mod 4096, wrapping silently.
REQ-021 The FSM SHALL have the states IDLE, DWELL and STEP.
REQ-022 In IDLE, freq_ctl SHALL equal F_START and sweep_active SHALL be 0.
REQ-023 IDLE SHALL go to DWELL on key_pulse[2]; the dwell counter loads DWELL_CYCLES-1 and sweep_active goes to 1.
REQ-024 DWELL SHALL decrement the counter each cycle and enter STEP the cycle after the counter is 0.
REQ-025 STEP SHALL last one cycle, update freq_ctl per REQ-027/REQ-032, reload the counter and return to DWELL.
REQ-026 key_pulse[2] in DWELL or STEP SHALL force IDLE on that edge, set freq_ctl to F_START and assert param_valid if freq_ctl changed; any STEP update in that cycle is discarded.
REQ-027 The frequency sum freq_ctl+F_STEP SHALL be formed at 33 bits; a sum no greater than F_STOP is loaded, and a sum greater than F_STOP loads F_START (sawtooth).
REQ-028 Each freq_ctl change SHALL produce one param_valid pulse, so the sweep emits exactly one pulse per STEP.

Reset
REQ-029 While sys_rst_n is low, the outputs SHALL be wave_select=4'b0001, amp_ctl=9'd256, freq_ctl=F_START, phase_ctl=0, sweep_active=0, param_valid=0, with the FSM in IDLE, the counter at 0 and the sweep direction up.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep immediately, and no param_valid pulse SHALL be produced on reset release.

Configuration
REQ-031 The macro DDS_SWEEP_TRIANGLE_EN SHALL select the sweep shape: undefined gives sawtooth per REQ-027 with no direction register.
REQ-032 With DDS_SWEEP_TRIANGLE_EN defined, the sweep SHALL be triangular: a 1-bit direction register is added; going up with sum > F_STOP, the direction flips to down and freq_ctl-F_STEP is loaded; going down with freq_ctl-F_STEP < F_START (33-bit signed compare), the direction flips to up and freq_ctl+F_STEP is loaded; every loaded result is clamped to [F_START, F_STOP]; entering IDLE resets the direction to up.

Verification (F_START=100, F_STOP=130, F_STEP=10, DWELL_CYCLES=4 unless noted)
REQ-033 Release reset, then pulse key[0] five times -> wave_select 0010,0100,1000,0001,0010, with 5 param_valid pulses each aligned to its change.
REQ-034 Pulse key[1], key[3] and key[0] in the same cycle -> next cycle amp_ctl=128, phase_ctl=1024, wave_select=0010, with exactly one param_valid.
REQ-035 Sawtooth: pulse key[2] -> freq_ctl 100,110,120,130,100,110, with each value held 5 cycles (4 dwell + 1 step) and sweep_active=1 throughout.
REQ-036 Triangle (macro defined): pulse key[2] -> freq_ctl 100,110,120,130,120,110,100,110.
REQ-037 Pulse key[2] while freq_ctl=120, coincident with a STEP cycle -> freq_ctl=100, sweep_active=0, state IDLE, with no 130.
REQ-038 Assert sys_rst_n low mid-DWELL with phase_ctl=3072 -> outputs return immediately to their reset values and stay there after release with no param_valid; pulse key[3] four times from 0 -> phase_ctl 1024,2048,3072,0.
